// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg
//   Shared definitions for the register-file write-port arbiter slice:
//   register-file data/address widths and the arbiter FSM state type.
//   No ports; imported by wb_arbiter and wb_fifo.
package wb_arbiter_pkg;

    localparam int unsigned WIDTH_REGWD = 32;  // register write-data width
    localparam int unsigned WIDTH_REGAD = 5;   // register address width

    typedef enum logic [1:0] {
        WBARB_IDLE  = 2'd0,  // FIFO empty, pipeline owns the port
        WBARB_WAIT  = 2'd1,  // FIFO non-empty, starvation counter running
        WBARB_FORCE = 2'd2   // limit reached, FIFO head takes the port
    } wbarb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo
//   Synchronous FIFO for long-latency results, payload {rd, wd}.
//   Ports:
//     clk, rst_n          clock, async active-low reset (empties the FIFO)
//     push/push_rd/wd     write an entry (ignored when full)
//     pop                 drop the head entry (ignored when empty)
//     head_rd/head_wd     head entry, valid while !empty
//     full/empty/count    registered occupancy status
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = WIDTH_REGAD,
    parameter int unsigned DATA_W = WIDTH_REGWD,
    parameter int unsigned DEPTH  = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_rd,
    input  logic [DATA_W-1:0] push_wd,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_rd,
    output logic [DATA_W-1:0] head_wd,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W+DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic                     push_ok;
    logic                     pop_ok;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign {head_rd, head_wd} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {push_rd, push_wd};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter
//   Shares the register-file write port between the pipeline WB stage and a
//   long-latency unit. Holds a result FIFO, a busy scoreboard of pending
//   long-latency destinations and a starvation-bounded arbiter.
//   Ports:
//     pipe_we/rd/wd       pipeline write-back request
//     hold_pipe           WB must re-present its write next cycle
//     issue_valid/rd      long-latency issue from EX, issue_ready accepts it
//     lu_valid/rd/wd      long-latency result, lu_ready accepts it
//     id_rs1/rs2/rd       ID operands, stall when any is busy
//     rf_we/wa/wd         register-file write port
//     outstanding         issued but not yet written long-latency ops
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W       = WIDTH_REGWD,
    parameter int unsigned ADDR_W       = WIDTH_REGAD,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned MAX_OUT      = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_rd,
    input  logic [DATA_W-1:0] pipe_wd,
    output logic              hold_pipe,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              issue_ready,
    input  logic              lu_valid,
    input  logic [ADDR_W-1:0] lu_rd,
    input  logic [DATA_W-1:0] lu_wd,
    output logic              lu_ready,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic [ADDR_W-1:0] id_rd,
    output logic              stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic [2:0]        outstanding
);

    localparam int unsigned NREG  = 1 << ADDR_W;
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);

    wbarb_state_t      state_q, state_d;
    logic [CNT_W-1:0]  wait_q, wait_d, wait_inc;
    logic [NREG-1:1]   busy_q;
    logic [NREG-1:0]   busy_vec;
    logic [2:0]        out_q;

    logic              pipe_req;
    logic              issue_ok;
    logic              lu_push;
    logic              pipe_grant;
    logic              fifo_grant;
    logic              fifo_full;
    logic              fifo_empty;
    logic [OCC_W-1:0]  fifo_count;
    logic [OCC_W-1:0]  occ_next;
    logic [ADDR_W-1:0] head_rd;
    logic [DATA_W-1:0] head_wd;

    assign pipe_req    = pipe_we && (pipe_rd != '0);
    assign busy_vec    = {busy_q, 1'b0};
    assign issue_ready = !busy_vec[issue_rd] && (out_q < 3'(MAX_OUT));
    assign issue_ok    = issue_valid && issue_ready;
    assign lu_ready    = !fifo_full;
    assign lu_push     = lu_valid && lu_ready;
    assign stall       = busy_vec[id_rs1] | busy_vec[id_rs2] | busy_vec[id_rd];
    assign outstanding = out_q;
    assign occ_next    = fifo_count + OCC_W'(lu_push) - OCC_W'(fifo_grant);
    assign wait_inc    = wait_q + 1'b1;

    wb_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (lu_push),
        .push_rd (lu_rd),
        .push_wd (lu_wd),
        .pop     (fifo_grant),
        .head_rd (head_rd),
        .head_wd (head_wd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WBARB_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            WBARB_IDLE: begin
                if (lu_push) begin
                    state_d = WBARB_WAIT;
                end
            end
            WBARB_WAIT: begin
                if (pipe_req) begin
                    wait_d = wait_inc;
                    if (wait_inc == CNT_W'(STARVE_LIMIT)) begin
                        state_d = WBARB_FORCE;
                    end
                end else begin
                    wait_d  = '0;
                    state_d = (occ_next == '0) ? WBARB_IDLE : WBARB_WAIT;
                end
            end
            WBARB_FORCE: begin
                wait_d  = '0;
                state_d = (occ_next == '0) ? WBARB_IDLE : WBARB_WAIT;
            end
            default: begin
                wait_d  = '0;
                state_d = WBARB_IDLE;
            end
        endcase
    end

    // Output logic: grant selection
    always_comb begin
        pipe_grant = 1'b0;
        fifo_grant = 1'b0;
        hold_pipe  = 1'b0;
        case (state_q)
            WBARB_IDLE: begin
                pipe_grant = pipe_req;
            end
            WBARB_WAIT: begin
                pipe_grant = pipe_req;
                fifo_grant = !pipe_req && !fifo_empty;
            end
            WBARB_FORCE: begin
                hold_pipe  = 1'b1;
                fifo_grant = !fifo_empty;
            end
            default: ;
        endcase
    end

    // Write port is a combinational mux; gated by rst_n so a pipe write
    // presented during reset never reaches the register file.
    always_comb begin
        rf_we = 1'b0;
        rf_wa = '0;
        rf_wd = '0;
        if (rst_n) begin
            if (pipe_grant) begin
                rf_we = 1'b1;
                rf_wa = pipe_rd;
                rf_wd = pipe_wd;
            end else if (fifo_grant) begin
                rf_we = (head_rd != '0);
                rf_wa = head_rd;
                rf_wd = head_wd;
            end
        end
    end

    // Scoreboard and outstanding count. A clear and a set never hit the same
    // register in one cycle because issue_ready blocks busy destinations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            out_q  <= '0;
        end else begin
            if (fifo_grant && (head_rd != '0)) begin
                busy_q[head_rd] <= 1'b0;
            end
            if (issue_ok && (issue_rd != '0)) begin
                busy_q[issue_rd] <= 1'b1;
            end
            case ({issue_ok, fifo_grant})
                2'b10:   out_q <= out_q + 1'b1;
                2'b01:   out_q <= out_q - 1'b1;
                default: out_q <= out_q;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter
//   Self-checking bench for wb_arbiter: a scripted vector table, hand-written
//   corner sequences and a randomized run against a queue-based model.
module tb_wb_arbiter;

    localparam int LIMIT = 4;
    localparam int DEPTH = 2;
    localparam int MAXO  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_wd;
    logic        hold_pipe;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_wd;
    logic        lu_ready;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        stall;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [2:0]  outstanding;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_arbiter #(
        .DATA_W       (32),
        .ADDR_W       (5),
        .FIFO_DEPTH   (DEPTH),
        .MAX_OUT      (MAXO),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pipe_we     (pipe_we),
        .pipe_rd     (pipe_rd),
        .pipe_wd     (pipe_wd),
        .hold_pipe   (hold_pipe),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .lu_valid    (lu_valid),
        .lu_rd       (lu_rd),
        .lu_wd       (lu_wd),
        .lu_ready    (lu_ready),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .stall       (stall),
        .rf_we       (rf_we),
        .rf_wa       (rf_wa),
        .rf_wd       (rf_wd),
        .outstanding (outstanding)
    );

    typedef struct {
        logic        pwe;
        logic [4:0]  prd;
        logic [31:0] pwd;
        logic        iv;
        logic [4:0]  ird;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] lwd;
        logic [4:0]  rs1;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_stall;
        logic        e_ir;
        logic        e_lr;
        logic [2:0]  e_out;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        pipe_we = 0; pipe_rd = 0; pipe_wd = 0;
        issue_valid = 0; issue_rd = 0;
        lu_valid = 0; lu_rd = 0; lu_wd = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    // Queue-based reference model state
    int unsigned q_rd [$];
    int unsigned q_wd [$];
    int unsigned pend [$];
    bit [31:0]   m_busy;
    int          m_out;
    int          m_starve;

    initial begin
        set_idle();
        rst_n = 0;

        // Reset values
        @(negedge clk);
        pipe_we = 1; pipe_rd = 4; pipe_wd = 32'h44;
        #1;
        check("rst_rf_we", 32'(rf_we), 0);
        check("rst_rf_wa", 32'(rf_wa), 0);
        check("rst_rf_wd", rf_wd, 0);
        check("rst_hold", 32'(hold_pipe), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_lu_ready", 32'(lu_ready), 1);
        check("rst_issue_ready", 32'(issue_ready), 1);
        check("rst_outstanding", 32'(outstanding), 0);
        set_idle();
        rst_n = 1;
        @(negedge clk);

        // Scripted table: pipe pass-through, x5 double issue, result timing
        //            pwe prd pwd           iv ird lv lrd lwd           rs1 we wa wd            st ir lr out
        vecs[0]  = '{1, 1, 32'h11,        0, 0, 0, 0, 0,             0, 1, 1, 32'h11,        0, 1, 1, 0};
        vecs[1]  = '{1, 0, 32'h22,        0, 0, 0, 0, 0,             0, 0, 0, 0,             0, 1, 1, 0};
        vecs[2]  = '{0, 0, 0,             1, 5, 0, 0, 0,             5, 0, 0, 0,             0, 1, 1, 0};
        vecs[3]  = '{0, 0, 0,             1, 5, 0, 0, 0,             5, 0, 0, 0,             1, 0, 1, 1};
        vecs[4]  = '{0, 0, 0,             1, 5, 1, 5, 32'hA5A5A5A5,  5, 0, 0, 0,             1, 0, 1, 1};
        vecs[5]  = '{0, 0, 0,             1, 5, 0, 0, 0,             5, 1, 5, 32'hA5A5A5A5,  1, 0, 1, 1};
        vecs[6]  = '{0, 0, 0,             1, 5, 0, 0, 0,             5, 0, 0, 0,             0, 1, 1, 0};
        vecs[7]  = '{1, 2, 32'h2222,      0, 0, 1, 5, 32'h5555,      5, 1, 2, 32'h2222,      1, 1, 1, 1};
        vecs[8]  = '{1, 3, 32'h3333,      0, 0, 0, 0, 0,             5, 1, 3, 32'h3333,      1, 1, 1, 1};
        vecs[9]  = '{0, 0, 0,             0, 0, 0, 0, 0,             5, 1, 5, 32'h5555,      1, 1, 1, 1};
        vecs[10] = '{0, 0, 0,             0, 0, 0, 0, 0,             5, 0, 0, 0,             0, 1, 1, 0};

        for (int i = 0; i < 11; i++) begin
            set_idle();
            pipe_we = vecs[i].pwe; pipe_rd = vecs[i].prd; pipe_wd = vecs[i].pwd;
            issue_valid = vecs[i].iv; issue_rd = vecs[i].ird;
            lu_valid = vecs[i].lv; lu_rd = vecs[i].lrd; lu_wd = vecs[i].lwd;
            id_rs1 = vecs[i].rs1;
            #1;
            check($sformatf("vec%0d_rf_we", i), 32'(rf_we), 32'(vecs[i].e_we));
            if (vecs[i].e_we) begin
                check($sformatf("vec%0d_rf_wa", i), 32'(rf_wa), 32'(vecs[i].e_wa));
                check($sformatf("vec%0d_rf_wd", i), rf_wd, vecs[i].e_wd);
            end
            check($sformatf("vec%0d_hold", i), 32'(hold_pipe), 0);
            check($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
            check($sformatf("vec%0d_issue_ready", i), 32'(issue_ready), 32'(vecs[i].e_ir));
            check($sformatf("vec%0d_lu_ready", i), 32'(lu_ready), 32'(vecs[i].e_lr));
            check($sformatf("vec%0d_outstanding", i), 32'(outstanding), 32'(vecs[i].e_out));
            @(negedge clk);
        end

        // Starvation: x3 waits behind a busy pipe, forced in the fifth cycle
        set_idle(); issue_valid = 1; issue_rd = 3;
        #1 check("starve_issue_ready", 32'(issue_ready), 1);
        @(negedge clk);
        set_idle(); lu_valid = 1; lu_rd = 3; lu_wd = 32'hDEADBEEF;
        pipe_we = 1; pipe_rd = 9; pipe_wd = 32'h900;
        #1 check("starve_push_wa", 32'(rf_wa), 9);
        @(negedge clk);
        lu_valid = 0; id_rs1 = 3;
        for (int k = 0; k < 4; k++) begin
            pipe_rd = 5'(10 + k); pipe_wd = 32'h0A00 + 32'(k);
            #1;
            check($sformatf("starve_win%0d_we", k), 32'(rf_we), 1);
            check($sformatf("starve_win%0d_wa", k), 32'(rf_wa), 32'(10 + k));
            check($sformatf("starve_win%0d_hold", k), 32'(hold_pipe), 0);
            check($sformatf("starve_win%0d_stall", k), 32'(stall), 1);
            @(negedge clk);
        end
        pipe_rd = 14; pipe_wd = 32'hE00;
        #1;
        check("force_hold", 32'(hold_pipe), 1);
        check("force_we", 32'(rf_we), 1);
        check("force_wa", 32'(rf_wa), 3);
        check("force_wd", rf_wd, 32'hDEADBEEF);
        @(negedge clk);
        #1;
        check("retire_hold", 32'(hold_pipe), 0);
        check("retire_wa", 32'(rf_wa), 14);
        check("retire_wd", rf_wd, 32'hE00);
        check("retire_stall", 32'(stall), 0);
        check("retire_out", 32'(outstanding), 0);
        @(negedge clk);

        // x7 result with idle pipe: written the cycle after acceptance
        set_idle(); issue_valid = 1; issue_rd = 7;
        @(negedge clk);
        set_idle(); lu_valid = 1; lu_rd = 7; lu_wd = 32'hDEADBEEF;
        #1 check("x7_accept_cycle_we", 32'(rf_we), 0);
        @(negedge clk);
        set_idle(); id_rs1 = 7;
        #1;
        check("x7_we", 32'(rf_we), 1);
        check("x7_wa", 32'(rf_wa), 7);
        check("x7_wd", rf_wd, 32'hDEADBEEF);
        check("x7_stall_n1", 32'(stall), 1);
        @(negedge clk);
        #1;
        check("x7_stall_n2", 32'(stall), 0);
        check("x7_out", 32'(outstanding), 0);
        @(negedge clk);

        // Fill the FIFO while the pipe is busy
        for (int k = 0; k < 3; k++) begin
            set_idle(); issue_valid = 1; issue_rd = 5'(10 + k);
            @(negedge clk);
        end
        set_idle(); pipe_we = 1; pipe_rd = 20; pipe_wd = 32'h2020;
        lu_valid = 1; lu_rd = 10; lu_wd = 32'h1010;
        #1 check("fill_lr0", 32'(lu_ready), 1);
        @(negedge clk);
        lu_rd = 11; lu_wd = 32'h1111;
        #1 check("fill_lr1", 32'(lu_ready), 1);
        @(negedge clk);
        lu_rd = 12; lu_wd = 32'h1212;
        for (int k = 0; k < 3; k++) begin
            #1 check($sformatf("fill_full%0d_lr", k), 32'(lu_ready), 0);
            @(negedge clk);
        end
        #1;
        check("fill_force_hold", 32'(hold_pipe), 1);
        check("fill_force_lr", 32'(lu_ready), 0);
        check("fill_force_wa", 32'(rf_wa), 10);
        @(negedge clk);
        #1;
        check("fill_after_lr", 32'(lu_ready), 1);
        check("fill_after_wa", 32'(rf_wa), 20);
        @(negedge clk);
        set_idle();
        #1 check("fill_drain11", 32'(rf_wa), 11);
        @(negedge clk);
        #1;
        check("fill_drain12_wa", 32'(rf_wa), 12);
        check("fill_drain12_wd", rf_wd, 32'h1212);
        @(negedge clk);
        #1;
        check("fill_done_we", 32'(rf_we), 0);
        check("fill_done_out", 32'(outstanding), 0);
        @(negedge clk);

        // rd = 0 issue and result
        set_idle(); issue_valid = 1; issue_rd = 0;
        #1 check("rd0_issue_ready", 32'(issue_ready), 1);
        @(negedge clk);
        set_idle(); lu_valid = 1; lu_rd = 0; lu_wd = 32'h1234;
        #1;
        check("rd0_out1", 32'(outstanding), 1);
        check("rd0_ready_again", 32'(issue_ready), 1);
        @(negedge clk);
        set_idle();
        #1;
        check("rd0_pop_we", 32'(rf_we), 0);
        check("rd0_pop_out", 32'(outstanding), 1);
        @(negedge clk);
        #1 check("rd0_out0", 32'(outstanding), 0);
        @(negedge clk);

        // Outstanding limit
        for (int k = 1; k <= 4; k++) begin
            set_idle(); issue_valid = 1; issue_rd = 5'(k);
            #1 check($sformatf("max_issue%0d", k), 32'(issue_ready), 1);
            @(negedge clk);
        end
        set_idle(); issue_valid = 1; issue_rd = 6;
        #1;
        check("max_fifth_ready", 32'(issue_ready), 0);
        check("max_out", 32'(outstanding), 4);
        @(negedge clk);

        // Two results queued behind a busy pipe, then asynchronous reset
        set_idle(); pipe_we = 1; pipe_rd = 20; pipe_wd = 32'h2020;
        lu_valid = 1; lu_rd = 1; lu_wd = 32'hAAAA;
        @(negedge clk);
        lu_rd = 2; lu_wd = 32'hBBBB;
        @(negedge clk);
        lu_valid = 0; id_rs1 = 1; issue_rd = 2;
        #1;
        check("pre_rst_stall", 32'(stall), 1);
        check("pre_rst_lr", 32'(lu_ready), 0);
        #1 rst_n = 0;
        #1;
        check("async_rf_we", 32'(rf_we), 0);
        check("async_rf_wa", 32'(rf_wa), 0);
        check("async_rf_wd", rf_wd, 0);
        check("async_hold", 32'(hold_pipe), 0);
        check("async_stall", 32'(stall), 0);
        check("async_lu_ready", 32'(lu_ready), 1);
        check("async_issue_ready", 32'(issue_ready), 1);
        check("async_out", 32'(outstanding), 0);
        @(negedge clk);
        set_idle(); id_rs1 = 1; id_rs2 = 2;
        rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("post_rst%0d_we", k), 32'(rf_we), 0);
            check($sformatf("post_rst%0d_stall", k), 32'(stall), 0);
            @(negedge clk);
        end

        // Randomized run against the queue model
        do_reset();
        q_rd.delete(); q_wd.delete(); pend.delete();
        m_busy = '0; m_out = 0; m_starve = 0;
        begin
            bit          hold_prev;
            bit          preq, force_w, fgrant, pgrant, e_we, acc_i, acc_l;
            int unsigned e_wa, e_wd, hrd;
            hold_prev = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                if (!hold_prev) begin
                    pipe_we = ($urandom_range(0, 3) != 0);
                    pipe_rd = 5'($urandom_range(0, 31));
                    pipe_wd = $urandom;
                end
                issue_valid = ($urandom_range(0, 2) == 0);
                issue_rd    = 5'($urandom_range(0, 7));
                lu_valid    = (pend.size() > 0) && ($urandom_range(0, 1) == 1);
                lu_rd       = (pend.size() > 0) ? 5'(pend[0]) : 5'd0;
                lu_wd       = $urandom;
                id_rs1      = 5'($urandom_range(0, 7));
                id_rs2      = 5'($urandom_range(0, 7));
                id_rd       = 5'($urandom_range(0, 7));
                #1;
                preq    = pipe_we && (pipe_rd != 0);
                force_w = (q_rd.size() > 0) && (m_starve >= LIMIT);
                fgrant  = (q_rd.size() > 0) && (force_w || !preq);
                pgrant  = preq && !force_w;
                hrd     = (q_rd.size() > 0) ? q_rd[0] : 0;
                e_we    = pgrant || (fgrant && hrd != 0);
                e_wa    = pgrant ? 32'(pipe_rd) : hrd;
                e_wd    = pgrant ? pipe_wd : ((q_wd.size() > 0) ? q_wd[0] : 0);

                check("rnd_rf_we", 32'(rf_we), 32'(e_we));
                if (e_we) begin
                    check("rnd_rf_wa", 32'(rf_wa), e_wa);
                    check("rnd_rf_wd", rf_wd, e_wd);
                end
                check("rnd_hold", 32'(hold_pipe), 32'(force_w));
                check("rnd_stall", 32'(stall),
                      32'(m_busy[id_rs1] | m_busy[id_rs2] | m_busy[id_rd]));
                check("rnd_issue_ready", 32'(issue_ready),
                      32'(!m_busy[issue_rd] && m_out < MAXO));
                check("rnd_lu_ready", 32'(lu_ready), 32'(q_rd.size() < DEPTH));
                check("rnd_outstanding", 32'(outstanding), 32'(m_out));

                acc_i = issue_valid && !m_busy[issue_rd] && (m_out < MAXO);
                acc_l = lu_valid && (q_rd.size() < DEPTH);
                if (fgrant) begin
                    if (hrd != 0) m_busy[hrd] = 1'b0;
                    void'(q_rd.pop_front());
                    void'(q_wd.pop_front());
                    m_out--;
                    m_starve = 0;
                end else if (q_rd.size() > 0 && pgrant) begin
                    m_starve++;
                end
                if (acc_i) begin
                    if (issue_rd != 0) m_busy[issue_rd] = 1'b1;
                    m_out++;
                    pend.push_back(32'(issue_rd));
                end
                if (acc_l) begin
                    q_rd.push_back(32'(lu_rd));
                    q_wd.push_back(lu_wd);
                    void'(pend.pop_front());
                end
                hold_prev = force_w;
                @(negedge clk);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
